alu_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational 64-bit ALU: same operation encoding and N/Z/V/C flag semantics, generalised to any even WIDTH, extended with two shift operations, a two-stage registered datapath with valid/ready handshakes on both sides, and an architectural NZVC flag register updated on demand. It sits between operand fetch and writeback in the pipelined CPU datapath, and under a stalling memory stage it holds results without loss.

---
 rtl/alu_pipe.sv | 115 +++++++++++
 tb/tb_alu_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides and an
// architectural NZVC flag register written when a setflags beat retires.
module alu_pipe #(
  parameter int unsigned WIDTH = 64,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       flags_q
);

  // Stage 1 operand registers
  logic             s1_valid;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             sf_q;

  // Stage 2 output registers
  logic             s2_sf;

  logic s2_load, accept, retire;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !reset && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  // Datapath
  logic [WIDTH-1:0] b_add, add_s, res_d;
  logic             add_c, cin, arith, v_d, c_d;

  always_comb begin
    cin   = (op_q == 3'b011);
    b_add = cin ? ~b_q : b_q;
    {add_c, add_s} = {1'b0, a_q} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
    arith = (op_q == 3'b010) || (op_q == 3'b011);
    res_d = '0;
    unique case (op_q)
      3'b000: res_d = b_q;
      3'b001: res_d = a_q << b_q[SHW-1:0];
      3'b010: res_d = add_s;
      3'b011: res_d = add_s;
      3'b100: res_d = a_q & b_q;
      3'b101: res_d = a_q | b_q;
      3'b110: res_d = a_q ^ b_q;
      3'b111: res_d = a_q >> b_q[SHW-1:0];
      default: res_d = '0;
    endcase
    // Signed overflow: operands agree in sign but the sum does not.
    v_d = arith && (a_q[WIDTH-1] == b_add[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
    c_d = arith && add_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sf_q     <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      a_q      <= A;
      b_q      <= B;
      op_q     <= cntrl;
      sf_q     <= setflags;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      s2_sf     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= res_d;
      negative  <= res_d[WIDTH-1];
      zero      <= (res_d == '0);
      overflow  <= v_d;
      carry_out <= c_d;
      s2_sf     <= sf_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (retire && s2_sf) begin
      flags_q <= {negative, zero, overflow, carry_out};
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed checks of alu_pipe against a queue-based reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0, B = '0;
  logic [2:0]  cntrl = '0;
  logic        setflags = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        negative, zero, overflow, carry_out;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  alu_pipe #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .setflags  (setflags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {N,Z,V,C, result} from plain arithmetic.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] op);
    logic [63:0] r;
    logic        v, c;
    logic [64:0] u;
    longint      sa, sb;
    logic signed [65:0] s;
    v = 1'b0;
    c = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: r = b;
      3'd1: r = a << b[5:0];
      3'd2: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[63:0];
        c = u[64];
        s = 66'(sa) + 66'(sb);
        v = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
        s = 66'(sa) - 66'(sb);
        v = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a >> b[5:0];
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  // Scoreboard: expected beats in accept order and the architectural flags.
  logic [68:0] exp_q[$];
  logic [3:0]  flags_m = 4'b0000;

  always @(negedge clk) begin
    logic [68:0] e;
    if (reset) begin
      exp_q.delete();
      flags_m = 4'b0000;
    end else begin
      check("flags_q", {60'd0, flags_q}, {60'd0, flags_m});
      if (in_valid && in_ready) exp_q.push_back({setflags, model(A, B, cntrl)});
      if (out_valid && out_ready) begin
        retired++;
        if (exp_q.size() == 0) begin
          check("stale_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", result, e[63:0]);
          check("sb_flags", {60'd0, negative, zero, overflow, carry_out}, {60'd0, e[67:64]});
          if (e[68]) flags_m = e[67:64];
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                      input logic sf);
    int n = 0;
    A = a; B = b; cntrl = op; setflags = sf; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                     input logic sf, input logic [63:0] er, input logic [3:0] ef,
                     input string tag);
    int n = 0;
    send(a, b, op, sf);
    while (!out_valid && n < 20) begin
      sync();
      n++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, ef});
    sync();
  endtask

  task automatic lat_beat(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                          input logic [63:0] er, input logic [3:0] ef, input string tag);
    send(a, b, op, 1'b1);
    check({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    sync();
    check({tag, "_lat"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, ef});
    sync();
    check({tag, "_fq"}, {60'd0, flags_q}, {60'd0, ef});
  endtask

  logic drv_done;

  initial begin
    logic [63:0] held;
    int n;
    // Reset state
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags_q", {60'd0, flags_q}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    sync();

    lat_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 4'b1010, "add_ovf");
    run(64'hDEAD_BEEF_DECA_FBAD, 64'hDEAD_BEEF_DECA_FBAD, 3'b011, 1'b1, 64'd0, 4'b0101, "sub_eq");
    run(64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, "sub_ovf");
    run(64'd1, 64'd63, 3'b001, 1'b0, 64'h8000_0000_0000_0000, 4'b1000, "shl");
    run(64'h8000_0000_0000_0000, 64'h43, 3'b111, 1'b0, 64'h1000_0000_0000_0000, 4'b0000, "shr");
    run(64'h1234, 64'h40, 3'b001, 1'b0, 64'h1234, 4'b0000, "shl0");
    // setflags gating: flags_q stays 0101 after a setflags=0 zero result
    run(64'hF0, 64'h0F, 3'b100, 1'b0, 64'd0, 4'b0100, "and_nosf");
    check("gate_hold", {60'd0, flags_q}, 64'h5);
    run(64'd0, 64'h8000_0000_0000_0000, 3'b000, 1'b1, 64'h8000_0000_0000_0000, 4'b1000, "pass_sf");
    check("gate_set", {60'd0, flags_q}, 64'h8);

    // Back-pressure with random beats
    retired = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
        drv_done = 1'b1;
      end
      begin
        out_ready = 1'b1;
        repeat (3) sync();
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        held = result;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_hold", result, held);
        end
        check("stall_full", {63'd0, in_ready}, 64'd0);
        sync();
        n = 0;
        while ((!drv_done || exp_q.size() != 0) && n < 500) begin
          out_ready = 1'($urandom_range(0, 1));
          sync();
          n++;
        end
        check("drain_timeout", {63'd0, (n >= 500)}, 64'd0);
      end
    join
    out_ready = 1'b1;
    check("stream_count", 64'(retired), 64'd10);

    // Asynchronous reset with two beats in flight
    sync();
    out_ready = 1'b0;
    send(64'd5, 64'd6, 3'b010, 1'b1);
    send(64'd7, 64'd8, 3'b110, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_flags", {60'd0, flags_q}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", {63'd0, out_valid}, 64'd0);
    end
    sync();
    lat_beat(64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "post_rst");
    repeat (2) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
